divu_hilo_unit: RTL and testbench

Multi-cycle unsigned divider with the architectural HI/LO register pair, sitting directly downstream of ALU control in the EX stage. It consumes the DIVU strobe and the 2-bit ALUSEL result select. DIVU starts a 32-step restoring division that writes LO=quotient and HI=remainder. ALUSEL steers HI, LO or the ALU result onto the EX result bus for mfhi/mflo. It raises busy so the hazard unit stalls the pipeline while a division is in flight.

---
 rtl/divu_hilo_unit.sv | 111 +++++++++++
 tb/tb_divu_hilo_unit.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/divu_hilo_unit.sv
// Multi-cycle unsigned restoring divider with the architectural HI/LO pair.
// Drives the EX result mux for mfhi/mflo and stalls the pipeline via busy.
module divu_hilo_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             divu,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic [1:0]       alusel,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] hilo_wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] ex_result
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH:0]   rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dsr;
  logic [CNT_W-1:0] cnt;

  logic [WIDTH+1:0] rem_sh;
  logic [WIDTH+1:0] trial;
  logic [WIDTH:0]   rem_nxt;
  logic [WIDTH-1:0] quo_nxt;
  logic             start;
  logic             last_step;

  assign start     = divu && (state != RUN);
  assign last_step = (cnt == CNT_W'(WIDTH - 1));

  // One restoring step: shift {rem, quo} left, try to subtract the divisor.
  always_comb begin
    rem_sh = {rem, quo[WIDTH-1]};
    trial  = rem_sh - {2'b00, dsr};
    if (trial[WIDTH+1]) begin
      rem_nxt = rem_sh[WIDTH:0];
      quo_nxt = {quo[WIDTH-2:0], 1'b0};
    end else begin
      rem_nxt = trial[WIDTH:0];
      quo_nxt = {quo[WIDTH-2:0], 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      rem   <= '0;
      quo   <= '0;
      dsr   <= '0;
      cnt   <= '0;
      hi    <= '0;
      lo    <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          rem <= rem_nxt;
          quo <= quo_nxt;
          cnt <= cnt + CNT_W'(1);
          if (last_step) begin
            lo    <= quo_nxt;
            hi    <= rem_nxt[WIDTH-1:0];
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: begin
          // mthi/mtlo land here; a coinciding division result overwrites them later
          if (hi_we) hi <= hilo_wdata;
          if (lo_we) lo <= hilo_wdata;
          if (start) begin
            quo   <= dividend;
            dsr   <= divisor;
            rem   <= '0;
            cnt   <= '0;
            state <= RUN;
            busy  <= 1'b1;
            done  <= 1'b0;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
          end
        end
      endcase
    end
  end

  // No bypass of the in-flight result; the stall covers mfhi/mflo during RUN.
  always_comb begin
    case (alusel)
      2'd0:    ex_result = hi;
      2'd1:    ex_result = lo;
      default: ex_result = alu_result;
    endcase
  end

endmodule

// File: tb/tb_divu_hilo_unit.sv
// Directed bench for divu_hilo_unit: divide results, busy/done timing,
// ignored/DONE-cycle starts, mid-operation reset, HI/LO writes and result mux.
module tb_divu_hilo_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        divu;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic [1:0]  alusel;
  logic [31:0] alu_result;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] hilo_wdata;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] ex_result;

  int checks   = 0;
  int failures = 0;

  divu_hilo_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .divu(divu), .dividend(dividend), .divisor(divisor),
    .alusel(alusel), .alu_result(alu_result), .hi_we(hi_we), .lo_we(lo_we),
    .hilo_wdata(hilo_wdata), .busy(busy), .done(done), .hi(hi), .lo(lo),
    .ex_result(ex_result)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Start a division, optionally pulse a (to-be-ignored) start mid-run,
  // count busy cycles and check the result in the DONE cycle.
  task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] elo, input logic [31:0] ehi, input bit inject);
    int n;
    divu = 1'b1; dividend = a; divisor = b;
    tick();
    divu = 1'b0; dividend = '0; divisor = '0;
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      if (inject && n == 9) begin
        divu = 1'b1; dividend = 32'd50; divisor = 32'd3;
      end else begin
        divu = 1'b0; dividend = '0; divisor = '0;
      end
      tick();
      n++;
    end
    divu = 1'b0;
    chk({tag, "_busy_cycles"}, 32'(n), 32'd32);
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_lo"}, lo, elo);
    chk({tag, "_hi"}, hi, ehi);
  endtask

  initial begin
    int dcount;
    rst_n = 1'b0; divu = 1'b0; dividend = '0; divisor = '0; alusel = 2'd2;
    alu_result = '0; hi_we = 1'b0; lo_we = 1'b0; hilo_wdata = '0;
    tick(); tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    rst_n = 1'b1;
    tick();

    run_div("d100_7", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
    tick();
    chk("d100_7_done_clear", 32'(done), 32'd0);
    chk("d100_7_busy_clear", 32'(busy), 32'd0);

    run_div("dmax_1", 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0);
    tick();
    run_div("d5_msb", 32'd5, 32'h8000_0000, 32'd0, 32'd5, 1'b0);
    tick();
    run_div("dmax_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0);
    tick();
    run_div("dzero", 32'h1234_ABCD, 32'd0, 32'hFFFF_FFFF, 32'h1234_ABCD, 1'b0);
    tick();

    // Start ignored during RUN, then a start in the DONE cycle is accepted
    run_div("d_ignored", 32'd100, 32'd7, 32'd14, 32'd2, 1'b1);
    run_div("d_from_done", 32'd50, 32'd3, 32'd16, 32'd2, 1'b0);
    tick();
    chk("d_from_done_idle", 32'(done), 32'd0);

    hi_we = 1'b1; hilo_wdata = 32'hAAAA_5555;
    tick();
    hi_we = 1'b0; lo_we = 1'b1; hilo_wdata = 32'h0000_0001;
    tick();
    lo_we = 1'b0; alu_result = 32'h1357_2468;
    alusel = 2'd0; #1 chk("mux_hi", ex_result, 32'hAAAA_5555);
    alusel = 2'd1; #1 chk("mux_lo", ex_result, 32'h0000_0001);
    alusel = 2'd2; #1 chk("mux_alu2", ex_result, 32'h1357_2468);
    alusel = 2'd3; #1 chk("mux_alu3", ex_result, 32'h1357_2468);

    // mthi while busy must be dropped
    divu = 1'b1; dividend = 32'd10; divisor = 32'd3;
    tick();
    divu = 1'b0; hi_we = 1'b1; hilo_wdata = 32'hDEAD_BEEF;
    tick();
    hi_we = 1'b0;
    chk("hi_we_in_run", hi, 32'hAAAA_5555);
    dcount = 0;
    while (busy === 1'b1 && dcount < 40) begin
      tick();
      dcount++;
    end
    chk("d10_3_lo", lo, 32'd3);
    chk("d10_3_hi", hi, 32'd1);
    tick();

    // Reset in the middle of 100/7: no result, no done pulse
    divu = 1'b1; dividend = 32'd100; divisor = 32'd7;
    tick();
    divu = 1'b0;
    for (int i = 0; i < 14; i++) tick();
    rst_n = 1'b0;
    tick();
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_hi", hi, 32'd0);
    chk("midrst_lo", lo, 32'd0);
    rst_n = 1'b1;
    dcount = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done === 1'b1 || busy === 1'b1) dcount++;
    end
    chk("midrst_no_done", 32'(dcount), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
